// File: rtl/garden_sensor_reader.sv
// garden_sensor_reader: periodically reads two channels of a 10-bit serial ADC
// (ch0 = soil moisture, ch1 = tank level) and turns each reading into a
// hysteresis-filtered flag for the sprinkler controller.
//
// Handshake: trig is a single-cycle request with no ready/ack. It is honoured
// only while the block is idling in ST_WAIT. In every other state it is
// dropped, and requests are never queued.
module garden_sensor_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter logic [9:0]  WET_ON        = 10'd400,
  parameter logic [9:0]  WET_OFF       = 10'd600,
  parameter logic [9:0]  LEVEL_ON      = 10'd300,
  parameter logic [9:0]  LEVEL_OFF     = 10'd150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic       moisture,
  output logic       water,
  output logic [9:0] moist_raw,
  output logic [9:0] level_raw,
  output logic       valid,
  output logic       sample_done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_FRAME0 = 3'd1,
    ST_GAP    = 3'd2,
    ST_FRAME1 = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  // One shared counter serves the idle wait and the SCLK half-period divider.
  localparam int unsigned CNT_TOP  = (SAMPLE_PERIOD > CLK_DIV) ? SAMPLE_PERIOD : CLK_DIV;
  localparam int          CW       = $clog2(CNT_TOP);
  localparam logic [CW-1:0] SP_LAST  = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  // Half-period index inside a frame: 0 is the lead-in after cs_n falls,
  // odd values are SCLK-high phases, 32 is the tail after the last fall.
  // HP_TAIL is a single cs_n-high cycle that closes FRAME1 before UPDATE.
  localparam logic [5:0] HP_LAST  = 6'd32;
  localparam logic [5:0] HP_TAIL  = 6'd33;
  // Rise k lands on half-period 2k-1; rises 7..16 carry result bits 9..0.
  localparam logic [5:0] HP_DATA0 = 6'd13;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]  hp_q, hp_d;
  logic [9:0]  shift_q, shift_d;
  logic [9:0]  ch0_q, ch0_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        moisture_q, moisture_d;
  logic        water_q, water_d;
  logic [9:0]  moist_raw_q, moist_raw_d;
  logic [9:0]  level_raw_q, level_raw_d;
  logic        valid_q, valid_d;
  logic        sample_done_q, sample_done_d;

  logic [5:0]  hp_inc;
  logic [4:0]  next_bit;
  logic        chan;

  assign hp_inc   = hp_q + 6'd1;
  // After SCLK fall k the next command bit to present is bit k+1.
  assign next_bit = hp_inc[5:1] + 5'd1;
  assign chan     = (state_q == ST_FRAME1);

  // Next-state and next-output logic for the whole read sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hp_d          = hp_q;
    shift_d       = shift_q;
    ch0_d         = ch0_q;
    sclk_d        = sclk_q;
    cs_n_d        = cs_n_q;
    mosi_d        = mosi_q;
    moisture_d    = moisture_q;
    water_d       = water_q;
    moist_raw_d   = moist_raw_q;
    level_raw_d   = level_raw_q;
    valid_d       = valid_q;
    sample_done_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (trig || (cnt_q == SP_LAST)) begin
          state_d = ST_FRAME0;
          cnt_d   = '0;
          hp_d    = '0;
          shift_d = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = 1'b1;              // command bit 1: start
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FRAME0, ST_FRAME1: begin
        if (hp_q == HP_TAIL) begin
          // Both readings are in hand: apply raws and flags together.
          state_d       = ST_UPDATE;
          moist_raw_d   = ch0_q;
          level_raw_d   = shift_q;
          if (ch0_q <= WET_ON)         moisture_d = 1'b1;
          else if (ch0_q >= WET_OFF)   moisture_d = 1'b0;
          if (shift_q >= LEVEL_ON)     water_d    = 1'b1;
          else if (shift_q <= LEVEL_OFF) water_d  = 1'b0;
          valid_d       = 1'b1;
          sample_done_d = 1'b1;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (hp_q == HP_LAST) begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (state_q == ST_FRAME0) begin
              state_d = ST_GAP;
              ch0_d   = shift_q;
            end else begin
              hp_d = HP_TAIL;
            end
          end else begin
            hp_d = hp_inc;
            if (hp_inc[0]) begin
              sclk_d = 1'b1;
              if (hp_inc >= HP_DATA0) shift_d = {shift_q[8:0], miso};
            end else begin
              sclk_d = 1'b0;
              case (next_bit)
                5'd2:    mosi_d = 1'b1;  // single-ended
                5'd5:    mosi_d = chan;  // channel select
                default: mosi_d = 1'b0;
              endcase
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_FRAME1;
          cnt_d   = '0;
          hp_d    = '0;
          shift_d = '0;
          cs_n_d  = 1'b0;
          mosi_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_UPDATE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      hp_q          <= '0;
      shift_q       <= '0;
      ch0_q         <= '0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      moisture_q    <= 1'b0;
      water_q       <= 1'b0;
      moist_raw_q   <= '0;
      level_raw_q   <= '0;
      valid_q       <= 1'b0;
      sample_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hp_q          <= hp_d;
      shift_q       <= shift_d;
      ch0_q         <= ch0_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      mosi_q        <= mosi_d;
      moisture_q    <= moisture_d;
      water_q       <= water_d;
      moist_raw_q   <= moist_raw_d;
      level_raw_q   <= level_raw_d;
      valid_q       <= valid_d;
      sample_done_q <= sample_done_d;
    end
  end

  assign sclk        = sclk_q;
  assign cs_n        = cs_n_q;
  assign mosi        = mosi_q;
  assign moisture    = moisture_q;
  assign water       = water_q;
  assign moist_raw   = moist_raw_q;
  assign level_raw   = level_raw_q;
  assign valid       = valid_q;
  assign sample_done = sample_done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_garden_sensor_reader.sv
// Bench for garden_sensor_reader: an ADC model answers each frame with the
// value programmed for the channel it decodes from mosi; expected flags come
// from the hysteresis rules applied to the sequence of readings.
module tb_garden_sensor_reader;

  localparam int H        = 2;
  localparam int SP       = 50;
  localparam int PAIR_CYC = 67 * H + 1;
  localparam logic [9:0] WET_ON    = 10'd400;
  localparam logic [9:0] WET_OFF   = 10'd600;
  localparam logic [9:0] LEVEL_ON  = 10'd300;
  localparam logic [9:0] LEVEL_OFF = 10'd150;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic miso = 1'b0;
  logic sclk, cs_n, mosi, moisture, water, valid, sample_done;
  logic [9:0] moist_raw, level_raw;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  garden_sensor_reader #(
    .CLK_DIV(H), .SAMPLE_PERIOD(SP),
    .WET_ON(WET_ON), .WET_OFF(WET_OFF), .LEVEL_ON(LEVEL_ON), .LEVEL_OFF(LEVEL_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .moisture(moisture), .water(water),
    .moist_raw(moist_raw), .level_raw(level_raw),
    .valid(valid), .sample_done(sample_done), .dbg_state(dbg_state)
  );

  // ---------------- ADC model ----------------
  logic [9:0]  adc_val [2];
  int          rise_cnt = 0;
  logic [15:0] mosi_bits = '0;
  logic        adc_ch = 1'b0;
  int          frame_rises [2];
  logic [15:0] frame_mosi [2];
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  int          idle_sclk_err = 0;
  logic [3:0]  bidx;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      rise_cnt  = 0;
      mosi_bits = '0;
    end
    if (!sclk_prev && sclk) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[14:0], mosi};
      if (rise_cnt == 5) adc_ch = mosi;
    end
    if (sclk_prev && !sclk) begin
      // After fall k the ADC presents result bit 15-k for k = 6..15.
      if (rise_cnt >= 6 && rise_cnt <= 15) begin
        bidx = 4'(15 - rise_cnt);
        miso = adc_val[adc_ch][bidx];
      end else begin
        miso = 1'b0;
      end
    end
    if (!cs_prev && cs_n) begin
      frame_rises[adc_ch] = rise_cnt;
      frame_mosi[adc_ch]  = mosi_bits;
    end
    if (cs_n && sclk) idle_sclk_err++;
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  // ---------------- scoreboard ----------------
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   sd_seen = 0;
  int   sd_double = 0;
  logic sd_prev = 1'b0;
  logic exp_moist = 1'b0;
  logic exp_water = 1'b0;
  logic [9:0] exp_q[$];
  int   last_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hysteresis rules applied to one new pair of readings.
  task automatic model_apply(input logic [9:0] r0, input logic [9:0] r1);
    if (r0 <= WET_ON) exp_moist = 1'b1;
    else if (r0 >= WET_OFF) exp_moist = 1'b0;
    if (r1 >= LEVEL_ON) exp_water = 1'b1;
    else if (r1 <= LEVEL_OFF) exp_water = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sample_done && sd_prev) sd_double++;
    if (sample_done) sd_seen++;
    sd_prev = sample_done;
  endtask

  task automatic wait_cs_fall(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cs_n === 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sample_done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic run_pair(input logic [9:0] v0, input logic [9:0] v1, input int exp_fall,
                          input string tag);
    int t0, td;
    logic [9:0] e0, e1;
    adc_val[0] = v0;
    adc_val[1] = v1;
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    wait_cs_fall(SP + 5, t0);
    check({tag, "_cs_fall"}, t0, exp_fall);
    wait_done(PAIR_CYC + 5, td);
    check({tag, "_done_cyc"}, td, t0 + PAIR_CYC);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    model_apply(e0, e1);
    check({tag, "_moist_raw"}, moist_raw, e0);
    check({tag, "_level_raw"}, level_raw, e1);
    check({tag, "_moisture"}, moisture, exp_moist);
    check({tag, "_water"}, water, exp_water);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_rises0"}, frame_rises[0], 16);
    check({tag, "_rises1"}, frame_rises[1], 16);
    last_done = td;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] walk0 [4];
    logic [9:0] walk1 [4];
    logic       walk_m [4];
    int s, t0, td, t1, sd_before;
    logic [9:0] r0, r1;

    walk0  = '{10'd500, 10'd600, 10'd500, 10'd400};
    walk1  = '{10'd200, 10'd150, 10'd200, 10'd300};
    walk_m = '{1'b1, 1'b0, 1'b0, 1'b1};

    adc_val[0] = 10'd350;
    adc_val[1] = 10'd500;
    frame_rises = '{0, 0};
    frame_mosi  = '{16'd0, 16'd0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_moisture", moisture, 0);
    check("rst_water", water, 0);
    check("rst_moist_raw", moist_raw, 0);
    check("rst_level_raw", level_raw, 0);
    check("rst_valid", valid, 0);
    check("rst_sample_done", sample_done, 0);

    // Release: this negedge lies in cycle 1.
    rst_n = 1'b1;
    cyc = 1;
    run_pair(10'd350, 10'd500, SP + 1, "first");
    check("first_done_186", last_done, 186);
    check("cmd_ch0", frame_mosi[0][15:11], 5'b11000);
    check("cmd_ch1", frame_mosi[1][15:11], 5'b11001);
    check("mosi_tail_zero", frame_mosi[1][10:0], 0);

    // Hysteresis walk, including equality with every threshold
    for (int i = 0; i < 4; i++) begin
      run_pair(walk0[i], walk1[i], last_done + SP + 1, $sformatf("walk%0d", i));
      check($sformatf("walk%0d_table", i), moisture, walk_m[i]);
    end

    // Fixed miso pattern
    run_pair(10'b1010011001, 10'd777, last_done + SP + 1, "pattern");
    check("pattern_hex", moist_raw, 10'h299);

    // Randomized readings concentrated around the thresholds
    for (int i = 0; i < 6; i++) begin
      r0 = 10'($urandom_range(350, 650));
      r1 = 10'($urandom_range(100, 350));
      run_pair(r0, r1, last_done + SP + 1, $sformatf("rand%0d", i));
    end

    // trig in WAIT cycle 10, then a stray trig inside FRAME0
    s = last_done;
    adc_val[0] = 10'd350;
    adc_val[1] = 10'd500;
    while (cyc < s + 10) tick();
    check("trig_pre_cs", cs_n, 1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("trig_cs_fall", cs_n, 0);
    t0 = cyc;
    repeat (10) tick();
    sd_before = sd_seen;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_done(PAIR_CYC + 5, td);
    check("trig_done_cyc", td, t0 + PAIR_CYC);
    model_apply(10'd350, 10'd500);
    check("trig_moisture", moisture, exp_moist);
    wait_cs_fall(SP + 5, t1);
    check("trig_no_queue", t1, td + SP + 1);
    check("trig_one_done", sd_seen - sd_before, 1);

    // Reset during FRAME1 rise 8
    while (cyc < t1 + 34 * H + 15 * H) tick();
    check("pre_rst_sclk", sclk, 1);
    check("pre_rst_moist", moisture, 1);
    sd_before = sd_seen;
    rst_n = 1'b0;
    tick();
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_moisture", moisture, 0);
    check("midrst_water", water, 0);
    check("midrst_valid", valid, 0);
    check("midrst_moist_raw", moist_raw, 0);
    repeat (2) tick();
    exp_moist = 1'b0;
    exp_water = 1'b0;
    rst_n = 1'b1;
    cyc = 1;
    // Mid-band readings: flags hold their reset value 0.
    run_pair(10'd500, 10'd200, SP + 1, "resume");
    check("resume_one_done", sd_seen - sd_before, 1);

    check("sclk_idle_low", idle_sclk_err, 0);
    check("sd_single_pulse", sd_double, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
